// File: rtl/gpu_pkg.sv
// Shared definitions for the CPU->GPU command path: command codes,
// framebuffer geometry and the draw engine state encoding.
package gpu_pkg;

  localparam int FB_W  = 64;
  localparam int FB_H  = 32;
  localparam int FB_AW = 11;

  localparam logic [3:0] GPU_CMD_NOP   = 4'd0;
  localparam logic [3:0] GPU_CMD_CLEAR = 4'd1;
  localparam logic [3:0] GPU_CMD_DRAW  = 4'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_PIX,
    S_PIX_WR
  } state_t;

endpackage

// File: rtl/gpu_draw_engine_if.sv
// Bundle of the draw engine's command, memory-read and framebuffer ports.
// The engine is the slave; the CPU/memory/framebuffer side is the master.
interface gpu_draw_engine_if;
  import gpu_pkg::*;

  logic [3:0]       gpu_cmd;
  logic [15:0]      gpu_draw_offset;
  logic [7:0]       gpu_draw_x;
  logic [7:0]       gpu_draw_y;
  logic [7:0]       gpu_draw_length;
  logic             gpu_cmd_submitted;
  logic             gpu_ready;
  logic             gpu_collision;

  logic             mem_read;
  logic [11:0]      mem_read_addr;
  logic [7:0]       mem_read_data;
  logic             mem_read_ack;

  logic [FB_AW-1:0] fb_addr;
  logic             fb_re;
  logic             fb_rdata;
  logic             fb_we;
  logic             fb_wdata;

  modport slave (
    input  gpu_cmd, gpu_draw_offset, gpu_draw_x, gpu_draw_y, gpu_draw_length,
    input  gpu_cmd_submitted,
    output gpu_ready, gpu_collision,
    output mem_read, mem_read_addr,
    input  mem_read_data, mem_read_ack,
    output fb_addr, fb_re, fb_we, fb_wdata,
    input  fb_rdata
  );

  modport master (
    output gpu_cmd, gpu_draw_offset, gpu_draw_x, gpu_draw_y, gpu_draw_length,
    output gpu_cmd_submitted,
    input  gpu_ready, gpu_collision,
    input  mem_read, mem_read_addr,
    output mem_read_data, mem_read_ack,
    input  fb_addr, fb_re, fb_we, fb_wdata,
    output fb_rdata
  );

endinterface

// File: rtl/gpu_draw_engine.sv
// Executes CLEAR and XOR sprite DRAW commands against the shared 1-bit
// framebuffer RAM, fetching sprite rows over the memory read port.
module gpu_draw_engine #(
  parameter int FB_W = gpu_pkg::FB_W,
  parameter int FB_H = gpu_pkg::FB_H
) (
  input  logic             clk,
  input  logic             rst_n,
  gpu_draw_engine_if.slave bus
);
  import gpu_pkg::*;

  // FB_W and FB_H are powers of two, so the low address bits do the wrap.
  localparam int XW = $clog2(FB_W);
  localparam int YW = $clog2(FB_H);
  localparam int CW = XW + YW;
  localparam logic [CW-1:0] CLR_LAST = '1;

  state_t        state_reg, state_next;
  logic          hold_reg, hold_next;
  logic          coll_reg, coll_next;
  logic [11:0]   offset_reg, offset_next;
  logic [XW-1:0] sx_reg, sx_next;
  logic [YW-1:0] sy_reg, sy_next;
  logic [3:0]    len_reg, len_next;
  logic [3:0]    row_reg, row_next;
  logic [2:0]    col_reg, col_next;
  logic [7:0]    data_reg, data_next;
  logic [CW-1:0] clr_reg, clr_next;

  logic [8:0]    px_sum, py_sum;
  logic [CW-1:0] pix_addr;
  logic          clipped;
  logic          advance;

  assign px_sum   = 9'(sx_reg) + 9'(col_reg);
  assign py_sum   = 9'(sy_reg) + 9'(row_reg);
  assign pix_addr = {py_sum[YW-1:0], px_sum[XW-1:0]};
  assign clipped  = (px_sum >= 9'(FB_W)) || (py_sum >= 9'(FB_H));

  assign bus.gpu_collision = coll_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      hold_reg   <= 1'b0;
      coll_reg   <= 1'b0;
      offset_reg <= '0;
      sx_reg     <= '0;
      sy_reg     <= '0;
      len_reg    <= '0;
      row_reg    <= '0;
      col_reg    <= '0;
      data_reg   <= '0;
      clr_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      hold_reg   <= hold_next;
      coll_reg   <= coll_next;
      offset_reg <= offset_next;
      sx_reg     <= sx_next;
      sy_reg     <= sy_next;
      len_reg    <= len_next;
      row_reg    <= row_next;
      col_reg    <= col_next;
      data_reg   <= data_next;
      clr_reg    <= clr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    hold_next   = 1'b0;
    coll_next   = coll_reg;
    offset_next = offset_reg;
    sx_next     = sx_reg;
    sy_next     = sy_reg;
    len_next    = len_reg;
    row_next    = row_reg;
    col_next    = col_reg;
    data_next   = data_reg;
    clr_next    = clr_reg;
    advance     = 1'b0;

    bus.gpu_ready     = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_read_addr = '0;
    bus.fb_addr       = '0;
    bus.fb_re         = 1'b0;
    bus.fb_we         = 1'b0;
    bus.fb_wdata      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // hold_reg gives NOP and zero-length DRAW their one busy cycle
        bus.gpu_ready = !hold_reg;
        if (bus.gpu_cmd_submitted && !hold_reg) begin
          offset_next = bus.gpu_draw_offset[11:0];
          sx_next     = bus.gpu_draw_x[XW-1:0];
          sy_next     = bus.gpu_draw_y[YW-1:0];
          len_next    = bus.gpu_draw_length[3:0];
          coll_next   = 1'b0;
          case (bus.gpu_cmd)
            GPU_CMD_CLEAR: begin
              state_next = S_CLEAR;
              clr_next   = '0;
            end
            GPU_CMD_DRAW: begin
              if (bus.gpu_draw_length[3:0] == 4'd0) begin
                hold_next = 1'b1;
              end else begin
                state_next = S_FETCH;
                row_next   = '0;
              end
            end
            default: hold_next = 1'b1;
          endcase
        end
      end
      S_CLEAR: begin
        bus.fb_we   = 1'b1;
        bus.fb_addr = FB_AW'(clr_reg);
        clr_next    = clr_reg + 1'b1;
        if (clr_reg == CLR_LAST) state_next = S_IDLE;
      end
      S_FETCH: begin
        bus.mem_read      = 1'b1;
        bus.mem_read_addr = offset_reg + 12'(row_reg);
        if (bus.mem_read_ack) begin
          data_next  = bus.mem_read_data;
          col_next   = '0;
          state_next = S_PIX;
        end
      end
      S_PIX: begin
        if (!data_reg[3'd7 - col_reg] || clipped) begin
          advance = 1'b1;
        end else begin
          bus.fb_re   = 1'b1;
          bus.fb_addr = FB_AW'(pix_addr);
          state_next  = S_PIX_WR;
        end
      end
      S_PIX_WR: begin
        bus.fb_we    = 1'b1;
        bus.fb_addr  = FB_AW'(pix_addr);
        bus.fb_wdata = ~bus.fb_rdata;
        coll_next    = coll_reg | bus.fb_rdata;
        state_next   = S_PIX;
        advance      = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase

    if (advance) begin
      col_next = col_reg + 1'b1;
      if (col_reg == 3'd7) begin
        row_next   = row_reg + 1'b1;
        state_next = (5'(row_reg) + 5'd1 == 5'(len_reg)) ? S_IDLE : S_FETCH;
      end
    end
  end

endmodule

// File: tb/tb_gpu_draw_engine.sv
// Directed bench for gpu_draw_engine with a latency-configurable sprite
// memory and a 1-cycle-read framebuffer RAM model.
module tb_gpu_draw_engine;
  import gpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gpu_draw_engine_if bus();

  gpu_draw_engine #(.FB_W(64), .FB_H(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int errors  = 0;

  // sprite memory: ack arrives lat_cfg+1 cycles after the request appears
  logic [7:0] rom [0:4095];
  int lat_cfg = 0;
  int wait_cnt = 0;
  always @(posedge clk) begin
    bus.mem_read_ack <= 1'b0;
    if (bus.mem_read && !bus.mem_read_ack) begin
      if (wait_cnt >= lat_cfg) begin
        bus.mem_read_ack  <= 1'b1;
        bus.mem_read_data <= rom[bus.mem_read_addr];
        wait_cnt          <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  logic fb_mem [0:2047];
  logic fb_init_req = 1'b0;
  logic fb_init_val = 1'b0;
  always @(posedge clk) begin
    if (fb_init_req) begin
      for (int i = 0; i < 2048; i++) fb_mem[i] <= fb_init_val;
    end else if (bus.fb_we) begin
      fb_mem[bus.fb_addr] <= bus.fb_wdata;
    end
    if (bus.fb_re) bus.fb_rdata <= fb_mem[bus.fb_addr];
  end

  int we_cnt, rd_cnt, both_cnt, addr_chg;
  logic clr_mon = 1'b0;
  logic prev_rd = 1'b0;
  logic [11:0] prev_addr = '0;
  always @(negedge clk) begin
    if (clr_mon) begin
      we_cnt <= 0; rd_cnt <= 0; both_cnt <= 0; addr_chg <= 0;
    end else if (rst_n) begin
      if (bus.fb_we) we_cnt <= we_cnt + 1;
      if (bus.mem_read) rd_cnt <= rd_cnt + 1;
      if (bus.fb_we && bus.fb_re) both_cnt <= both_cnt + 1;
      if (bus.mem_read && prev_rd && bus.mem_read_addr != prev_addr) addr_chg <= addr_chg + 1;
    end
    prev_rd   <= bus.mem_read;
    prev_addr <= bus.mem_read_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int fb_ones();
    int s = 0;
    for (int i = 0; i < 2048; i++) if (fb_mem[i] === 1'b1) s++;
    return s;
  endfunction

  task automatic fill(input logic v);
    @(negedge clk);
    fb_init_val = v;
    fb_init_req = 1'b1;
    @(negedge clk);
    fb_init_req = 1'b0;
  endtask

  task automatic clear_counts();
    @(posedge clk);
    clr_mon = 1'b1;
    @(negedge clk);
    #1 clr_mon = 1'b0;
  endtask

  // returns at the negedge just after the accepting edge (cycle 1)
  task automatic submit(input logic [3:0] cmd, input logic [15:0] off,
                        input logic [7:0] x, input logic [7:0] y, input logic [7:0] len);
    @(negedge clk);
    bus.gpu_cmd           = cmd;
    bus.gpu_draw_offset   = off;
    bus.gpu_draw_x        = x;
    bus.gpu_draw_y        = y;
    bus.gpu_draw_length   = len;
    bus.gpu_cmd_submitted = 1'b1;
    @(negedge clk);
    bus.gpu_cmd_submitted = 1'b0;
  endtask

  // n = index of the first cycle with gpu_ready high
  task automatic wait_ready(output int n);
    n = 1;
    while (!bus.gpu_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.gpu_ready) chk("ready_timeout", 32'(bus.gpu_ready), 32'd1);
  endtask

  task automatic run_cmd(input logic [3:0] cmd, input logic [15:0] off, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] len, output int busy);
    int n;
    clear_counts();
    submit(cmd, off, x, y, len);
    wait_ready(n);
    busy = n - 1;
    $display("cmd=%0d off=%h x=%0d y=%0d len=%0d busy=%0d writes=%0d coll=%0b",
             cmd, off, x, y, len, busy, we_cnt, bus.gpu_collision);
  endtask

  initial begin
    int busy;
    int n;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h100] = 8'hF0;
    rom[12'h200] = 8'hFF;
    rom[12'h201] = 8'hFF;
    rom[12'h300] = 8'h81;
    rom[12'hFFF] = 8'h80;
    rom[12'h000] = 8'h80;
    rom[12'h400] = 8'hFF;

    rst_n = 1'b0;
    bus.gpu_cmd = '0; bus.gpu_draw_offset = '0; bus.gpu_draw_x = '0;
    bus.gpu_draw_y = '0; bus.gpu_draw_length = '0; bus.gpu_cmd_submitted = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.gpu_ready), 32'd1);
    chk("rst_coll", 32'(bus.gpu_collision), 32'd0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_read_addr), 32'd0);
    chk("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
    chk("rst_fb_re", 32'(bus.fb_re), 32'd0);
    chk("rst_fb_we_wdata", 32'({bus.fb_we, bus.fb_wdata}), 32'd0);
    rst_n = 1'b1;

    // CLEAR over an all-ones framebuffer
    fill(1'b1);
    clear_counts();
    submit(GPU_CMD_CLEAR, 16'h0, 8'd0, 8'd0, 8'd0);
    chk("clr_busy_c1", 32'(bus.gpu_ready), 32'd0);
    wait_ready(n);
    $display("CLEAR ready_cycle=%0d writes=%0d", n, we_cnt);
    chk("clr_ready_cycle", 32'(n), 32'd2049);
    chk("clr_writes", 32'(we_cnt), 32'd2048);
    chk("clr_fb_zero", 32'(fb_ones()), 32'd0);
    chk("clr_coll", 32'(bus.gpu_collision), 32'd0);

    // 0xF0 at origin, then the same again to erase it
    run_cmd(GPU_CMD_DRAW, 16'h0100, 8'd0, 8'd0, 8'd1, busy);
    chk("d1_busy", 32'(busy), 32'd14);
    chk("d1_pixels", 32'({fb_mem[0], fb_mem[1], fb_mem[2], fb_mem[3]}), 32'hF);
    chk("d1_ones", 32'(fb_ones()), 32'd4);
    chk("d1_coll", 32'(bus.gpu_collision), 32'd0);
    chk("d1_writes", 32'(we_cnt), 32'd4);
    run_cmd(GPU_CMD_DRAW, 16'h0100, 8'd0, 8'd0, 8'd1, busy);
    chk("d2_ones", 32'(fb_ones()), 32'd0);
    chk("d2_coll", 32'(bus.gpu_collision), 32'd1);

    // bottom-right clipping
    run_cmd(GPU_CMD_DRAW, 16'h0200, 8'd62, 8'd31, 8'd2, busy);
    chk("clip_busy", 32'(busy), 32'd22);
    chk("clip_writes", 32'(we_cnt), 32'd2);
    chk("clip_pixels", 32'({fb_mem[2046], fb_mem[2047]}), 32'h3);
    chk("clip_ones", 32'(fb_ones()), 32'd2);
    chk("clip_overlap", 32'(both_cnt), 32'd0);

    // start coordinates wrap: (70,40) lands on (6,8)
    fill(1'b0);
    run_cmd(GPU_CMD_DRAW, 16'h0300, 8'd70, 8'd40, 8'd1, busy);
    chk("wrap_busy", 32'(busy), 32'd12);
    chk("wrap_pixels", 32'({fb_mem[518], fb_mem[525]}), 32'h3);
    chk("wrap_ones", 32'(fb_ones()), 32'd2);
    run_cmd(GPU_CMD_DRAW, 16'h0300, 8'd6, 8'd8, 8'd1, busy);
    chk("wrap_same_ones", 32'(fb_ones()), 32'd0);
    chk("wrap_same_coll", 32'(bus.gpu_collision), 32'd1);

    // zero-length DRAW and unknown command
    run_cmd(GPU_CMD_DRAW, 16'h0100, 8'd0, 8'd0, 8'd0, busy);
    chk("len0_busy", 32'(busy), 32'd1);
    chk("len0_reads", 32'(rd_cnt), 32'd0);
    chk("len0_coll", 32'(bus.gpu_collision), 32'd0);
    run_cmd(4'd7, 16'h0100, 8'd0, 8'd0, 8'd1, busy);
    chk("nop_busy", 32'(busy), 32'd1);
    chk("nop_writes", 32'(we_cnt), 32'd0);

    // slow memory, address wrap from 0xFFF to 0x000
    lat_cfg = 5;
    run_cmd(GPU_CMD_DRAW, 16'hFFFF, 8'd10, 8'd3, 8'd2, busy);
    chk("slow_busy", 32'(busy), 32'd32);
    chk("slow_addr_stable", 32'(addr_chg), 32'd0);
    chk("slow_pixels", 32'({fb_mem[202], fb_mem[266]}), 32'h3);
    chk("slow_ones", 32'(fb_ones()), 32'd2);

    // submit while busy is dropped
    fill(1'b0);
    clear_counts();
    submit(GPU_CMD_DRAW, 16'h0100, 8'd0, 8'd0, 8'd1);
    repeat (3) @(negedge clk);
    bus.gpu_cmd = GPU_CMD_CLEAR;
    bus.gpu_cmd_submitted = 1'b1;
    @(negedge clk);
    bus.gpu_cmd_submitted = 1'b0;
    wait_ready(n);
    repeat (4) @(negedge clk);
    $display("busy-submit writes=%0d ready=%0b", we_cnt, bus.gpu_ready);
    chk("ign_writes", 32'(we_cnt), 32'd4);
    chk("ign_ones", 32'(fb_ones()), 32'd4);
    chk("ign_ready", 32'(bus.gpu_ready), 32'd1);

    // asynchronous reset during a pixel write
    lat_cfg = 0;
    submit(GPU_CMD_DRAW, 16'h0400, 8'd20, 8'd20, 8'd1);
    repeat (3) @(negedge clk);
    chk("mid_fb_we", 32'(bus.fb_we), 32'd1);
    rst_n = 1'b0;
    #1;
    $display("async reset: ready=%0b mem_read=%0b fb_we=%0b", bus.gpu_ready, bus.mem_read, bus.fb_we);
    chk("arst_ready", 32'(bus.gpu_ready), 32'd1);
    chk("arst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("arst_fb_we", 32'(bus.fb_we), 32'd0);
    chk("arst_fb_re", 32'(bus.fb_re), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
